// File: rtl/iteration_controller_pkg.sv
// rtl/iteration_controller_pkg.sv - shared state encoding and width default for the iteration controller
package iteration_controller_pkg;

  localparam int CNT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/iteration_controller_if.sv
// rtl/iteration_controller_if.sv - sequence request, datapath strobe and counter bundle
interface iteration_controller_if
  import iteration_controller_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] iter_len;
  logic             step_ready;
  logic [CNT_W-1:0] count;
  logic             cnt_clear;
  logic             cnt_en;
  logic             load;
  logic             step;
  logic             busy;
  logic             done;
  logic             last_iter;

  modport master (
    output start, abort, iter_len, step_ready, count,
    input  cnt_clear, cnt_en, load, step, busy, done, last_iter
  );

  modport slave (
    input  start, abort, iter_len, step_ready, count,
    output cnt_clear, cnt_en, load, step, busy, done, last_iter
  );
endinterface

// File: rtl/five_bit_counter.sv
// rtl/five_bit_counter.sv - up counter with synchronous clear, driven by the iteration controller's parent
module five_bit_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         count_enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count_enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/iteration_controller.sv
// rtl/iteration_controller.sv - sequences iter_len+1 datapath steps using an external iteration counter
module iteration_controller
  import iteration_controller_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  iteration_controller_if.slave ctl
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] len_q;
  logic             at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      len_q <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && ctl.start) begin
        len_q <= ctl.iter_len;
      end
    end
  end

  assign at_last = (ctl.count == len_q);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (ctl.start) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ctl.abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (ctl.abort) begin
          state_nx = ST_IDLE;
        end else if (ctl.step_ready && at_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // The counter is never enabled on the final step, so it parks at len_q instead of wrapping.
  always_comb begin
    ctl.cnt_clear = 1'b0;
    ctl.cnt_en    = 1'b0;
    ctl.load      = 1'b0;
    ctl.step      = 1'b0;
    ctl.busy      = 1'b0;
    ctl.done      = 1'b0;
    ctl.last_iter = 1'b0;
    case (state)
      ST_IDLE: ctl.cnt_clear = 1'b1;
      ST_LOAD: begin
        ctl.cnt_clear = 1'b1;
        ctl.busy      = 1'b1;
        ctl.load      = !ctl.abort;
      end
      ST_RUN: begin
        ctl.busy      = 1'b1;
        ctl.last_iter = at_last;
        ctl.step      = ctl.step_ready && !ctl.abort;
        ctl.cnt_en    = ctl.step_ready && !ctl.abort && !at_last;
      end
      ST_DONE: begin
        ctl.busy = 1'b1;
        ctl.done = 1'b1;
      end
      default: ctl.cnt_clear = 1'b1;
    endcase
  end

endmodule
